// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - state encoding, March C- element table and background generator
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_WR,
    RUN_RD,
    RUN_WAIT,
    FIN
  } state_t;

  localparam logic [2:0] LAST_ELEM = 3'd5;

  // One bit per element E0..E5 (bits 6/7 unused): up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
  localparam logic [7:0] EL_DOWN   = 8'b0011_1000;
  localparam logic [7:0] EL_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] EL_RD_ONE = 8'b0001_0100;
  localparam logic [7:0] EL_HAS_WR = 8'b0001_1111;
  localparam logic [7:0] EL_WR_ONE = 8'b0000_1010;

  function automatic logic [255:0] alt_pattern(int width);
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < width && i < 256; i += 2) p[i] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// rtl/ram_march_bist_if.sv - RAM pin bundle between the BIST engine and the memory
interface ram_march_bist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_out;
  logic              D_oe;
  logic [DATA_W-1:0] D_in;
  logic              we;
  logic              re;

  modport master (output A, D_out, D_oe, we, re, input D_in);
  modport slave  (input A, D_out, D_oe, we, re, output D_in);
endinterface

// File: rtl/ram_bist_addr_gen.sv
// rtl/ram_bist_addr_gen.sv - up/down address counter over 0..DEPTH-1
module ram_bist_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic              dir,
  input  logic              dir_next,
  output logic [ADDR_W-1:0] addr,
  output logic              last_addr,
  output logic              wrap
);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  assign last_addr = dir ? (addr == '0) : (addr == TOP);
  assign wrap      = step & last_addr;

  // On wrap the counter preloads the start address of the following element
  always_ff @(posedge clk) begin
    if (rst || clr)  addr <= '0;
    else if (wrap)   addr <= dir_next ? TOP : '0;
    else if (step)   addr <= dir ? addr - 1'b1 : addr + 1'b1;
  end
endmodule

// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - March C- BIST engine driving a single-port RAM
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 16,
  parameter int RD_LAT       = 1,
  parameter int ERR_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bg_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  ram_march_bist_if.master  ram
);
  localparam int                WAIT_W    = $clog2(RD_LAT + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LAT - 1);
  localparam logic [255:0]      ALT_FULL  = alt_pattern(DATA_W);
  localparam logic [DATA_W-1:0] ALT       = ALT_FULL[DATA_W-1:0];

  state_t            state, state_nx;
  logic [2:0]        elem, elem_nx;
  logic              bg, fin_seen;
  logic [WAIT_W-1:0] wcnt;
  logic [ADDR_W-1:0] addr;
  logic              last_addr, wrap, step, cmp, mismatch, start_ok;
  logic [DATA_W-1:0] pat, rd_exp, wr_data;

  assign elem_nx  = elem + 3'd1;
  assign start_ok = (state == IDLE) && start;

  ram_bist_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .step      (step),
    .dir       (EL_DOWN[elem]),
    .dir_next  (EL_DOWN[elem_nx]),
    .addr      (addr),
    .last_addr (last_addr),
    .wrap      (wrap)
  );

  assign pat      = bg ? (ALT ^ {DATA_W{addr[0]}}) : '0;
  assign rd_exp   = EL_RD_ONE[elem] ? ~pat : pat;
  assign wr_data  = EL_WR_ONE[elem] ? ~pat : pat;
  assign mismatch = (ram.D_in != rd_exp);

  // step marks the last operation of an address; it chooses the next op or element
  always_comb begin
    state_nx = state;
    step     = 1'b0;
    cmp      = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = RUN_WR;
      RUN_WR:   step = 1'b1;
      RUN_RD:   state_nx = RUN_WAIT;
      RUN_WAIT: if (wcnt == LAST_WAIT) begin
        cmp = 1'b1;
        if (mismatch && STOP_ON_FAIL != 0) state_nx = FIN;
        else if (EL_HAS_WR[elem])          state_nx = RUN_WR;
        else                               step = 1'b1;
      end
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (step) begin
      if (!last_addr)             state_nx = EL_HAS_RD[elem] ? RUN_RD : RUN_WR;
      else if (elem == LAST_ELEM) state_nx = FIN;
      else                        state_nx = EL_HAS_RD[elem_nx] ? RUN_RD : RUN_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= '0;
      bg        <= 1'b0;
      wcnt      <= '0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      fin_seen  <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= (state == RUN_WAIT) ? wcnt + 1'b1 : '0;
      if (wrap) elem <= elem_nx;
      if (state == FIN) fin_seen <= 1'b1;
      if (start_ok) begin
        elem      <= '0;
        bg        <= bg_sel;
        err_count <= '0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
        fin_seen  <= 1'b0;
      end
      if (cmp && mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr <= addr;
          fail_exp  <= rd_exp;
          fail_got  <= ram.D_in;
        end
      end
    end
  end

  assign busy      = (state == RUN_WR) || (state == RUN_RD) || (state == RUN_WAIT);
  assign done      = (state == FIN);
  assign pass      = (done || fin_seen) && (err_count == '0);
  assign ram.we    = (state == RUN_WR);
  assign ram.re    = (state == RUN_RD);
  assign ram.D_oe  = ram.we;
  assign ram.D_out = ram.we ? wr_data : '0;
  assign ram.A     = busy ? addr : '0;
endmodule

// File: tb/tb_ram_march_bist.sv
// tb/tb_ram_march_bist.sv - scoreboard bench for ram_march_bist with a faulty-RAM model
module tb_ram_march_bist;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NI = 2;

  function automatic int depth_of(int i); return (i == 0) ? 4 : 6; endfunction
  function automatic int rdlat_of(int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int errw_of(int i);  return (i == 0) ? 3 : 4; endfunction
  function automatic int stop_of(int i);  return (i == 0) ? 0 : 1; endfunction

  typedef struct { bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  typedef struct { int cyc; int errs; bit pass; logic [AW-1:0] fa; logic [DW-1:0] fe; logic [DW-1:0] fg; } res_t;

  logic clk;
  logic rst [NI];
  logic start [NI];
  logic bg_sel [NI];
  logic busy [NI];
  logic done [NI];
  logic pass [NI];
  logic [7:0] errc [NI];
  logic [AW-1:0] faddr [NI];
  logic [DW-1:0] fexp [NI];
  logic [DW-1:0] fgot [NI];
  logic [AW-1:0] a_mon [NI];
  logic [DW-1:0] dout_mon [NI];
  logic oe_mon [NI];
  logic we_mon [NI];
  logic re_mon [NI];
  logic [DW-1:0] f_and [NI][64];
  logic [DW-1:0] f_or [NI][64];

  op_t  op_q [NI][$];
  res_t res_q [NI][$];
  int   bcnt [NI];
  int   vectors = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = depth_of(g);
    localparam int RL = rdlat_of(g);
    localparam int EW = errw_of(g);

    ram_march_bist_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    logic [EW-1:0] ec;
    logic [DW-1:0] mem [D];
    logic [DW-1:0] rword;
    logic [AW-1:0] raddr = '0;
    int            rcnt = 0;

    ram_march_bist #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(RL), .ERR_W(EW), .STOP_ON_FAIL(stop_of(g))
    ) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .start     (start[g]),
      .bg_sel    (bg_sel[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (ec),
      .fail_addr (faddr[g]),
      .fail_exp  (fexp[g]),
      .fail_got  (fgot[g]),
      .ram       (bus)
    );

    assign errc[g]     = 8'(ec);
    assign a_mon[g]    = bus.A;
    assign dout_mon[g] = bus.D_out;
    assign oe_mon[g]   = bus.D_oe;
    assign we_mon[g]   = bus.we;
    assign re_mon[g]   = bus.re;

    // Read data is only valid on the last wait cycle; any other cycle returns the complement
    always @(posedge clk) begin
      if (bus.we && int'(bus.A) < D) mem[int'(bus.A)] <= bus.D_out;
      if (bus.re) begin
        rcnt  <= RL;
        raddr <= bus.A;
      end else if (rcnt != 0) begin
        rcnt <= rcnt - 1;
      end
    end
    assign rword    = (mem[int'(raddr) % D] & f_and[g][int'(raddr) % D]) | f_or[g][int'(raddr) % D];
    assign bus.D_in = (rcnt == 1) ? rword : ~rword;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 64; a++) begin
        f_and[i][a] = '1;
        f_or[i][a]  = '0;
      end
  endtask

  // March C- walked address by address over an ideal memory seen through the fault masks
  task automatic build_expect(input int i, input bit bg, output res_t r);
    int d, rl, sat, a, rd_pol [6], wr_pol [6];
    bit down [6];
    bit halt;
    logic [DW-1:0] m [64];
    logic [DW-1:0] p, ex, got, w;
    d = depth_of(i);
    rl = rdlat_of(i);
    sat = (1 << errw_of(i)) - 1;
    rd_pol = '{-1, 0, 1, 0, 1, 0};
    wr_pol = '{0, 1, 0, 1, 0, -1};
    down   = '{0, 0, 0, 1, 1, 1};
    halt = 0;
    r = '{cyc: 0, errs: 0, pass: 1, fa: '0, fe: '0, fg: '0};
    for (int e = 0; e < 6 && !halt; e++) begin
      for (int k = 0; k < d && !halt; k++) begin
        a = down[e] ? d - 1 - k : k;
        p = bg ? ((a % 2 == 0) ? 8'h55 : 8'hAA) : 8'h00;
        if (rd_pol[e] >= 0) begin
          ex  = (rd_pol[e] == 1) ? ~p : p;
          got = (m[a] & f_and[i][a]) | f_or[i][a];
          op_q[i].push_back('{wr: 1'b0, a: AW'(a), d: ex});
          r.cyc += 1 + rl;
          if (got !== ex) begin
            if (r.pass) begin
              r.fa = AW'(a);
              r.fe = ex;
              r.fg = got;
            end
            r.pass = 0;
            if (r.errs < sat) r.errs++;
            if (stop_of(i) != 0) halt = 1;
          end
        end
        if (!halt && wr_pol[e] >= 0) begin
          w = (wr_pol[e] == 1) ? ~p : p;
          op_q[i].push_back('{wr: 1'b1, a: AW'(a), d: w});
          m[a] = w;
          r.cyc += 1;
        end
      end
    end
    res_q[i].push_back(r);
  endtask

  always @(negedge clk) begin : monitor
    op_t  o;
    res_t r;
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        bcnt[i] = 0;
      end else begin
        if (busy[i]) bcnt[i]++;
        if (we_mon[i] || re_mon[i]) begin
          check($sformatf("i%0d we_re_exclusive", i), 32'(we_mon[i] & re_mon[i]), 0);
          check($sformatf("i%0d oe_equals_we", i), 32'(oe_mon[i]), 32'(we_mon[i]));
          if (op_q[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL i%0d unexpected_op: got we=%0b re=%0b A=%0d, required no access", i, we_mon[i], re_mon[i], a_mon[i]);
          end else begin
            o = op_q[i].pop_front();
            check($sformatf("i%0d op_is_write", i), 32'(we_mon[i]), 32'(o.wr));
            check($sformatf("i%0d op_addr", i), 32'(a_mon[i]), 32'(o.a));
            if (o.wr) check($sformatf("i%0d write_data", i), 32'(dout_mon[i]), 32'(o.d));
          end
        end
        if (done[i]) begin
          if (res_q[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL i%0d unexpected_done: got done=1, required no test running", i);
          end else begin
            r = res_q[i].pop_front();
            check($sformatf("i%0d busy_cycles", i), 32'(bcnt[i]), 32'(r.cyc));
            check($sformatf("i%0d err_count", i), 32'(errc[i]), 32'(r.errs));
            check($sformatf("i%0d pass", i), 32'(pass[i]), 32'(r.pass));
            check($sformatf("i%0d fail_addr", i), 32'(faddr[i]), 32'(r.fa));
            check($sformatf("i%0d fail_exp", i), 32'(fexp[i]), 32'(r.fe));
            check($sformatf("i%0d fail_got", i), 32'(fgot[i]), 32'(r.fg));
            check($sformatf("i%0d ops_left_at_done", i), 32'(op_q[i].size()), 0);
          end
          bcnt[i] = 0;
        end
      end
    end
  end

  task automatic pulse_start(input int i, input bit bg);
    @(posedge clk); #1;
    start[i]  = 1'b1;
    bg_sel[i] = bg;
    @(posedge clk); #1;
    start[i]  = 1'b0;
    bg_sel[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int i, input bit bg, input bit extra);
    res_t r;
    int n;
    build_expect(i, bg, r);
    pulse_start(i, bg);
    if (extra) begin
      repeat (2) @(posedge clk);
      #1;
      start[i]  = 1'b1;
      bg_sel[i] = !bg;
      @(posedge clk); #1;
      start[i]  = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < 2000);
    check($sformatf("i%0d done_seen", i), 32'(done[i]), 1);
    @(negedge clk);
    check($sformatf("i%0d done_single_cycle", i), 32'(done[i]), 0);
    check($sformatf("i%0d pass_held", i), 32'(pass[i]), 32'(r.pass));
  endtask

  task automatic check_idle(input int i);
    check($sformatf("i%0d idle_busy", i), 32'(busy[i]), 0);
    check($sformatf("i%0d idle_done", i), 32'(done[i]), 0);
    check($sformatf("i%0d idle_pass", i), 32'(pass[i]), 0);
    check($sformatf("i%0d idle_err", i), 32'(errc[i]), 0);
    check($sformatf("i%0d idle_fail_addr", i), 32'(faddr[i]), 0);
    check($sformatf("i%0d idle_fail_exp", i), 32'(fexp[i]), 0);
    check($sformatf("i%0d idle_fail_got", i), 32'(fgot[i]), 0);
    check($sformatf("i%0d idle_A", i), 32'(a_mon[i]), 0);
    check($sformatf("i%0d idle_D_out", i), 32'(dout_mon[i]), 0);
    check($sformatf("i%0d idle_oe_we_re", i), {29'd0, oe_mon[i], we_mon[i], re_mon[i]}, 0);
  endtask

  task automatic reset_mid(input int i);
    res_t r;
    int d, rl;
    d = depth_of(i);
    rl = rdlat_of(i);
    build_expect(i, 1'b1, r);
    pulse_start(i, 1'b1);
    repeat (d * (rl + 3) + 3) @(posedge clk);
    #1;
    rst[i] = 1'b1;
    op_q[i].delete();
    res_q[i].delete();
    @(posedge clk); #1;
    rst[i] = 1'b0;
    @(negedge clk);
    check_idle(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int i, nf, a, b;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      start[k] = 1'b0;
      bg_sel[k] = 1'b0;
      bcnt[k] = 0;
    end
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_idle(k);

    run(0, 1'b0, 1'b0);
    check("solid_good_err", 32'(errc[0]), 0);
    run(0, 1'b1, 1'b0);
    check("checker_good_pass", 32'(pass[0]), 1);

    clear_faults();
    f_or[0][2] = 8'h01;
    run(0, 1'b0, 1'b0);
    check("stuck1_err_count", 32'(errc[0]), 3);
    check("stuck1_fail_addr", 32'(faddr[0]), 2);
    check("stuck1_fail_exp", 32'(fexp[0]), 32'h00);
    check("stuck1_fail_got", 32'(fgot[0]), 32'h01);

    clear_faults();
    f_or[1][2] = 8'h01;
    run(1, 1'b0, 1'b0);
    check("stop_err_count", 32'(errc[1]), 1);
    check("stop_fail_addr", 32'(faddr[1]), 2);

    clear_faults();
    for (int k = 0; k < 64; k++) f_and[0][k] = '0;
    run(0, 1'b0, 1'b1);
    check("saturated_err_count", 32'(errc[0]), 7);

    clear_faults();
    reset_mid(0);
    run(0, 1'b1, 1'b0);
    check("rerun_after_reset_pass", 32'(pass[0]), 1);

    for (int n = 0; n < 12; n++) begin
      clear_faults();
      i  = int'($urandom_range(0, NI - 1));
      nf = int'($urandom_range(0, 2));
      for (int f = 0; f < nf; f++) begin
        a = int'($urandom_range(0, depth_of(i) - 1));
        b = int'($urandom_range(0, DW - 1));
        if ($urandom_range(0, 1) == 1) f_or[i][a][b] = 1'b1;
        else                           f_and[i][a][b] = 1'b0;
      end
      run(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("i%0d ops_left_at_end", k), 32'(op_q[k].size()), 0);
      check($sformatf("i%0d results_left_at_end", k), 32'(res_q[k].size()), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
